// File: rtl/sincos_quarter_lut_mc_pkg.sv
// Shared types and helpers for the multi-channel quarter-wave sin/cos lookup.
// Quadrant encoding, Q-format helper and the elaboration-time ROM entry function.
package sincos_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  localparam real HALF_PI = 1.5707963267948966;

  function automatic int oneQ(input int frac);
    return 1 << frac;
  endfunction

  // Quadrants 1 and 3 read the quarter table backwards; 2 and 3 negate.
  function automatic logic quadMirror(input logic [1:0] q);
    return (quad_e'(q) == QUAD_1) || (quad_e'(q) == QUAD_3);
  endfunction

  function automatic logic quadNegate(input logic [1:0] q);
    return (quad_e'(q) == QUAD_2) || (quad_e'(q) == QUAD_3);
  endfunction

  // Endpoints are pinned so the table hits exactly 0 and full scale.
  function automatic int romEntry(input int i, input int lutAw, input int frac);
    int  last;
    real ang;
    last = (1 << lutAw) - 1;
    if (i <= 0) return 0;
    if (i >= last) return oneQ(frac);
    ang = HALF_PI * real'(i) / real'(last);
    return $rtoi($sin(ang) * real'(oneQ(frac)) + 0.5);
  endfunction

endpackage

// File: rtl/sincos_quarter_lut_mc_rom.sv
// Quarter-wave sine ROM with two registered read ports sharing one enable.
// Contents are computed at elaboration from sincos_pkg::romEntry.
module sincos_quarter_rom
  import sincos_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int WIDTH  = 18,
  parameter int FRAC   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [LUT_AW-1:0] i_addrA,
  input  logic [LUT_AW-1:0] i_addrB,
  output logic [WIDTH-1:0]  o_dataA,
  output logic [WIDTH-1:0]  o_dataB
);

  localparam int L = 1 << LUT_AW;

  logic [WIDTH-1:0] w_rom [L];
  logic [WIDTH-1:0] r_dataA;
  logic [WIDTH-1:0] r_dataB;

  for (genvar g = 0; g < L; g++) begin : g_rom
    assign w_rom[g] = WIDTH'(romEntry(g, LUT_AW, FRAC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataA <= '0;
      r_dataB <= '0;
    end else if (i_en) begin
      r_dataA <= w_rom[i_addrA];
      r_dataB <= w_rom[i_addrB];
    end
  end

  assign o_dataA = r_dataA;
  assign o_dataB = r_dataB;

endmodule

// File: rtl/sincos_quarter_lut_mc.sv
// Multi-channel sin/cos lookup from a shared quarter-wave ROM with per-channel
// phase accumulators. Define SINCOS_LUT_INTERP_EN for linear interpolation (+1 stage).
module sincos_quarter_lut_mc
  import sincos_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int FRAC    = 14,
  parameter int PHASE_W = 12,
  parameter int LUT_AW  = 8,
  parameter int NCH     = 4,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic               in_mode,
  input  logic [CH_W-1:0]    in_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sin,
  output logic [WIDTH-1:0]   out_cos,
  output logic [CH_W-1:0]    out_ch,
  output logic [PHASE_W-1:0] out_phase
);

  localparam logic [LUT_AW-1:0] IDX_MAX = '1;

  function automatic logic [LUT_AW-1:0] baseAddr(input logic [1:0] q, input logic [LUT_AW-1:0] idx);
    return quadMirror(q) ? IDX_MAX - idx : idx;
  endfunction

  logic               w_en;
  logic               w_accept;
  logic               w_chLegal;
  logic [PHASE_W-1:0] w_accSel;
  logic [PHASE_W-1:0] w_theta;
  logic [1:0]         w_qS;
  logic [1:0]         w_qC;
  logic [LUT_AW-1:0]  w_idx;

  logic [PHASE_W-1:0] r_acc [NCH];

  logic               r_s0Valid, r_s0NegS, r_s0NegC;
  logic [CH_W-1:0]    r_s0Ch;
  logic [PHASE_W-1:0] r_s0Phase;
  logic [LUT_AW-1:0]  r_s0AddrS, r_s0AddrC;

  logic               r_s1Valid, r_s1NegS, r_s1NegC;
  logic [CH_W-1:0]    r_s1Ch;
  logic [PHASE_W-1:0] r_s1Phase;
  logic [WIDTH-1:0]   w_romS, w_romC;

  logic               w_preValid, w_preNegS, w_preNegC;
  logic [CH_W-1:0]    w_preCh;
  logic [PHASE_W-1:0] w_prePhase;
  logic [WIDTH-1:0]   w_preMagS, w_preMagC;

  logic               r_outValid;
  logic [CH_W-1:0]    r_outCh;
  logic [PHASE_W-1:0] r_outPhase;
  logic [WIDTH-1:0]   r_outSin, r_outCos;

  assign w_en      = !r_outValid || out_ready;
  assign in_ready  = rst_n && w_en;
  assign w_accept  = in_valid && in_ready;
  assign w_chLegal = (32'(in_ch) < NCH);

  always_comb begin
    w_accSel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (in_ch == CH_W'(c)) w_accSel = r_acc[c];
    end
  end

  // Illegal channels fall back to absolute phase and never touch an accumulator.
  assign w_theta = (in_mode && w_chLegal) ? w_accSel + in_phase : in_phase;
  assign w_qS    = w_theta[PHASE_W-1 -: 2];
  assign w_idx   = w_theta[PHASE_W-3 -: LUT_AW];
  // Adding a quarter turn only moves the quadrant; idx and frac are shared.
  assign w_qC    = w_qS + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else if (w_accept && w_chLegal) begin
      for (int c = 0; c < NCH; c++) begin
        if (in_ch == CH_W'(c)) r_acc[c] <= w_theta;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0Valid <= 1'b0;
      r_s0Ch    <= '0;
      r_s0Phase <= '0;
      r_s0AddrS <= '0;
      r_s0AddrC <= '0;
      r_s0NegS  <= 1'b0;
      r_s0NegC  <= 1'b0;
    end else if (w_en) begin
      r_s0Valid <= w_accept;
      r_s0Ch    <= in_ch;
      r_s0Phase <= w_theta;
      r_s0AddrS <= baseAddr(w_qS, w_idx);
      r_s0AddrC <= baseAddr(w_qC, w_idx);
      r_s0NegS  <= quadNegate(w_qS);
      r_s0NegC  <= quadNegate(w_qC);
    end
  end

  sincos_quarter_rom #(
    .LUT_AW (LUT_AW),
    .WIDTH  (WIDTH),
    .FRAC   (FRAC)
  ) u_romBase (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_en),
    .i_addrA (r_s0AddrS),
    .i_addrB (r_s0AddrC),
    .o_dataA (w_romS),
    .o_dataB (w_romC)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Ch    <= '0;
      r_s1Phase <= '0;
      r_s1NegS  <= 1'b0;
      r_s1NegC  <= 1'b0;
    end else if (w_en) begin
      r_s1Valid <= r_s0Valid;
      r_s1Ch    <= r_s0Ch;
      r_s1Phase <= r_s0Phase;
      r_s1NegS  <= r_s0NegS;
      r_s1NegC  <= r_s0NegC;
    end
  end

`ifdef SINCOS_LUT_INTERP_EN
  localparam int FB = PHASE_W - 2 - LUT_AW;
  localparam int FW = (FB > 0) ? FB : 1;
  localparam int PW = WIDTH + FW + 2;
  localparam logic [PHASE_W-1:0] FRAC_MASK = PHASE_W'((64'd1 << FB) - 64'd1);

  function automatic logic [LUT_AW-1:0] nextAddr(input logic [1:0] q, input logic [LUT_AW-1:0] idx);
    if (quadMirror(q)) return (idx == IDX_MAX) ? '0 : IDX_MAX - LUT_AW'(1) - idx;
    return (idx == IDX_MAX) ? IDX_MAX : idx + LUT_AW'(1);
  endfunction

  // Difference is signed: the mirrored quadrants walk down the table.
  function automatic logic [WIDTH-1:0] lerp(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] n,
                                            input logic [FW-1:0] f);
    logic signed [PW-1:0] diff;
    logic signed [PW-1:0] prod;
    diff = signed'(PW'(n)) - signed'(PW'(b));
    prod = diff * signed'(PW'(f));
    return WIDTH'(signed'(PW'(b)) + (prod >>> FB));
  endfunction

  logic [LUT_AW-1:0] r_s0AddrNS, r_s0AddrNC;
  logic [FW-1:0]     r_s0Frac, r_s1Frac;
  logic [WIDTH-1:0]  w_romNS, w_romNC;
  logic              r_s2Valid, r_s2NegS, r_s2NegC;
  logic [CH_W-1:0]   r_s2Ch;
  logic [PHASE_W-1:0] r_s2Phase;
  logic [WIDTH-1:0]  r_s2MagS, r_s2MagC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0AddrNS <= '0;
      r_s0AddrNC <= '0;
      r_s0Frac   <= '0;
      r_s1Frac   <= '0;
    end else if (w_en) begin
      r_s0AddrNS <= nextAddr(w_qS, w_idx);
      r_s0AddrNC <= nextAddr(w_qC, w_idx);
      r_s0Frac   <= FW'(w_theta & FRAC_MASK);
      r_s1Frac   <= r_s0Frac;
    end
  end

  sincos_quarter_rom #(
    .LUT_AW (LUT_AW),
    .WIDTH  (WIDTH),
    .FRAC   (FRAC)
  ) u_romNext (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_en),
    .i_addrA (r_s0AddrNS),
    .i_addrB (r_s0AddrNC),
    .o_dataA (w_romNS),
    .o_dataB (w_romNC)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Ch    <= '0;
      r_s2Phase <= '0;
      r_s2NegS  <= 1'b0;
      r_s2NegC  <= 1'b0;
      r_s2MagS  <= '0;
      r_s2MagC  <= '0;
    end else if (w_en) begin
      r_s2Valid <= r_s1Valid;
      r_s2Ch    <= r_s1Ch;
      r_s2Phase <= r_s1Phase;
      r_s2NegS  <= r_s1NegS;
      r_s2NegC  <= r_s1NegC;
      r_s2MagS  <= lerp(w_romS, w_romNS, r_s1Frac);
      r_s2MagC  <= lerp(w_romC, w_romNC, r_s1Frac);
    end
  end

  assign w_preValid = r_s2Valid;
  assign w_preCh    = r_s2Ch;
  assign w_prePhase = r_s2Phase;
  assign w_preNegS  = r_s2NegS;
  assign w_preNegC  = r_s2NegC;
  assign w_preMagS  = r_s2MagS;
  assign w_preMagC  = r_s2MagC;
`else
  assign w_preValid = r_s1Valid;
  assign w_preCh    = r_s1Ch;
  assign w_prePhase = r_s1Phase;
  assign w_preNegS  = r_s1NegS;
  assign w_preNegC  = r_s1NegC;
  assign w_preMagS  = w_romS;
  assign w_preMagC  = w_romC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outCh    <= '0;
      r_outPhase <= '0;
      r_outSin   <= '0;
      r_outCos   <= '0;
    end else if (w_en) begin
      r_outValid <= w_preValid;
      r_outCh    <= w_preCh;
      r_outPhase <= w_prePhase;
      r_outSin   <= w_preNegS ? -w_preMagS : w_preMagS;
      r_outCos   <= w_preNegC ? -w_preMagC : w_preMagC;
    end
  end

  assign out_valid = r_outValid;
  assign out_ch    = r_outCh;
  assign out_phase = r_outPhase;
  assign out_sin   = r_outSin;
  assign out_cos   = r_outCos;

endmodule

// File: tb/tb_sincos_quarter_lut_mc.sv
// Self-checking bench for sincos_quarter_lut_mc (default build, latency 3).
// Table vectors plus hand sequences; expected results flow through a scoreboard queue.
module tb_sincos_quarter_lut_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_phase = '0;
  logic        in_mode = 1'b0;
  logic [1:0]  in_ch = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] out_sin;
  logic [17:0] out_cos;
  logic [1:0]  out_ch;
  logic [11:0] out_phase;

  typedef struct {
    int sinV;
    int cosV;
    int ch;
    int phase;
  } exp_t;

  typedef struct {
    int phase;
    int mode;
    int ch;
    int expSin;
    int expCos;
    int expPhase;
  } vec_t;

  exp_t expQ[$];
  exp_t monE;
  int   tests = 0;
  int   fails = 0;
  int   modelAcc[4];

  sincos_quarter_lut_mc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_phase  (in_phase),
    .in_mode   (in_mode),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sin   (out_sin),
    .out_cos   (out_cos),
    .out_ch    (out_ch),
    .out_phase (out_phase)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int romVal(input int i);
    real a;
    if (i == 0) return 0;
    if (i == 255) return 16384;
    a = (3.14159265358979323846 / 2.0) * real'(i) / 255.0;
    return $rtoi($sin(a) * 16384.0 + 0.5);
  endfunction

  function automatic int lookup(input int th);
    int q;
    int idx;
    int m;
    q   = (th >> 10) & 3;
    idx = (th >> 2) & 255;
    m   = (q == 1 || q == 3) ? romVal(255 - idx) : romVal(idx);
    return (q >= 2) ? -m : m;
  endfunction

  // Reference accumulator model, advanced in request order.
  function automatic exp_t modelRequest(input int ph, input int md, input int ch);
    exp_t e;
    int   th;
    th = (md != 0) ? ((modelAcc[ch] + ph) & 4095) : (ph & 4095);
    modelAcc[ch] = th;
    e.sinV  = lookup(th);
    e.cosV  = lookup((th + 1024) & 4095);
    e.ch    = ch;
    e.phase = th;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input int ph, input int md, input int ch, input exp_t e);
    int waitCnt;
    waitCnt  = 0;
    in_valid = 1'b1;
    in_phase = 12'(ph);
    in_mode  = md[0];
    in_ch    = 2'(ch);
    @(negedge clk);
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      checkOutput("accept timeout", 0, 1);
    end else begin
      expQ.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain pending", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected result", 1, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("out_sin", longint'($signed(out_sin)), monE.sinV);
        checkOutput("out_cos", longint'($signed(out_cos)), monE.cosV);
        checkOutput("out_ch", out_ch, monE.ch);
        checkOutput("out_phase", out_phase, monE.phase);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[9];
    exp_t e;
    int   lat;
    int   ch;
    int   inc;
    logic done;

    vecs[0] = '{0,    0, 0, 0,      16384,  0};
    vecs[1] = '{1024, 0, 1, 16384,  0,      1024};
    vecs[2] = '{2048, 0, 1, 0,      -16384, 2048};
    vecs[3] = '{3072, 0, 1, -16384, 0,      3072};
    vecs[4] = '{0,    0, 2, 0,      16384,  0};
    vecs[5] = '{1024, 1, 2, 16384,  0,      1024};
    vecs[6] = '{1024, 1, 2, 0,      -16384, 2048};
    vecs[7] = '{1024, 1, 2, -16384, 0,      3072};
    vecs[8] = '{1024, 1, 2, 0,      16384,  0};
    for (int c = 0; c < 4; c++) modelAcc[c] = 0;

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset out_sin", out_sin, 0);
    checkOutput("reset out_cos", out_cos, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      void'(modelRequest(vecs[i].phase, vecs[i].mode, vecs[i].ch));
      e.sinV  = vecs[i].expSin;
      e.cosV  = vecs[i].expCos;
      e.ch    = vecs[i].ch;
      e.phase = vecs[i].expPhase;
      applyStimulus(vecs[i].phase, vecs[i].mode, vecs[i].ch, e);
      if (i == 0) begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!out_valid && lat < 10);
        checkOutput("latency", lat, 3);
        @(posedge clk);
        #1;
        drain();
      end
    end
    drain();

    for (int i = 0; i < 8; i++) begin
      ch  = (i % 2 == 0) ? 0 : 3;
      inc = (ch == 0) ? 256 : 512;
      applyStimulus(inc, 1, ch, modelRequest(inc, 1, ch));
    end
    drain();

    fork
      begin
        for (int k = 0; k < 4; k++)
          applyStimulus(k * 1024 + 37, 0, 1, modelRequest(k * 1024 + 37, 0, 1));
      end
      begin
        logic [49:0] snap;
        int seen;
        seen = 0;
        snap = '0;
        out_ready = 1'b0;
        repeat (8) begin
          @(negedge clk);
          if (out_valid) begin
            if (seen == 0) snap = {out_sin, out_cos, out_ch, out_phase};
            else checkOutput("stall hold", longint'({out_sin, out_cos, out_ch, out_phase}), longint'(snap));
            seen++;
          end
        end
        checkOutput("stall in_ready", in_ready, 0);
        checkOutput("stall out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int ph;
          int md;
          int rc;
          ph = int'($urandom_range(0, 4095));
          md = int'($urandom_range(0, 1));
          rc = int'($urandom_range(0, 3));
          applyStimulus(ph, md, rc, modelRequest(ph, md, rc));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    applyStimulus(300, 1, 2, modelRequest(300, 1, 2));
    applyStimulus(400, 1, 2, modelRequest(400, 1, 2));
    applyStimulus(500, 0, 3, modelRequest(500, 0, 3));
    checkOutput("pre-reset out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", out_valid, 0);
    checkOutput("mid reset in_ready", in_ready, 0);
    expQ.delete();
    for (int c = 0; c < 4; c++) modelAcc[c] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = modelRequest(100, 1, 2);
    checkOutput("post reset model phase", e.phase, 100);
    applyStimulus(100, 1, 2, e);
    drain();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sincos_quarter_lut_mc.md
Name: sincos_quarter_lut_mc

Overview:
Parametrised, multi-channel successor to the single-channel quarter-wave sine lookup. Produces a sine and cosine pair in Q(FRAC) from a shared quarter-wave ROM, using a valid/ready pipeline with a channel tag. Optional per-channel phase accumulation lets one instance serve NCH oscillators time-multiplexed in the energy-landscape and force datapaths.

Parameters:
WIDTH, 18, signed output width
FRAC, 14, fractional bits; full scale = 2^FRAC
PHASE_W, 12, phase width, 0..2^PHASE_W-1 = 0..2π; must be >= LUT_AW+2
LUT_AW, 8, quarter-ROM address width; L = 2^LUT_AW entries
NCH, 4, channel count; CH_W = max(1,clog2(NCH)) derived locally

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_phase  in  PHASE_W  absolute phase (mode 0) or increment (mode 1)
in_mode  in  1  0 = absolute/load, 1 = accumulate
in_ch  in  CH_W  channel tag; values >= NCH are illegal
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_sin  out  WIDTH  signed sin(θ) in Q(FRAC)
out_cos  out  WIDTH  signed cos(θ) in Q(FRAC)
out_ch  out  CH_W  channel tag of the result
out_phase  out  PHASE_W  phase θ actually looked up

Behaviour:
- Single clock clk. Reset rst_n is asynchronous and active-low. While reset is asserted: all pipeline valids, out_* and every accumulator are 0, and in_ready is 0.
- ROM: entry i = round(sin(π/2·i/(L-1))·2^FRAC). Entry 0 = 0; entry L-1 = 2^FRAC exactly.
- Phase split: θ[PHASE_W-1:PHASE_W-2] = quadrant; next LUT_AW bits = idx; remaining low bits = frac.
- Quadrant mapping: q0 → +ROM[idx]; q1 → +ROM[L-1-idx]; q2 → -ROM[idx]; q3 → -ROM[L-1-idx]. Negating 0 gives 0.
- Cosine: lookup of θc = θ + 2^(PHASE_W-2), taken mod 2^PHASE_W. Both lookups are read in the same cycle (dual-read ROM).
- Accumulators: acc[NCH], each PHASE_W bits, updated on acceptance only.
  - Mode 0: θ = in_phase; acc[in_ch] <= in_phase.
  - Mode 1: θ = acc[in_ch] + in_phase, wrapping mod 2^PHASE_W; acc[in_ch] <= θ.
  - Back-to-back accepts on the same channel see the already-updated value; no hazard is possible.
- Pipeline stages, all advanced by en = !out_valid | out_ready; in_ready = en (and not in reset):
  - S0: phase select and accumulate, quadrant/address decode.
  - S1: ROM read, with sign flags delayed alongside.
  - S2: sign apply; registers out_*.
- Latency: 3 cycles from accept to out_valid when out_ready is held high. Throughput: 1 per cycle.
- Backpressure: while out_valid & !out_ready, every stage and all out_* hold stable, and nothing is accepted.
- Illegal in_ch (>= NCH): request is consumed; result uses θ = in_phase; no accumulator is written.
- Reset asserted mid-operation: in-flight results are discarded and accumulators cleared.

Optional Feature:
SINCOS_LUT_INTERP_EN.
- Defined:
  - Linear interpolation using the frac bits: y = b + (((n-b)·frac) >>> (PHASE_W-2-LUT_AW)).
  - q0/q2: b = ROM[idx], n = ROM[min(idx+1, L-1)].
  - q1/q3: b = ROM[L-1-idx], n = ROM[max(L-2-idx, 0)].
  - Sign is applied after interpolation. One extra stage is added: latency 4.
  - If PHASE_W = LUT_AW+2, frac is empty, results are identical to the undefined case, and latency is still 4.
- Undefined: frac bits are ignored (truncated); latency 3.

Decomposition:
- Package sincos_pkg:
  - Q-format constants (ONE_Q = 2^FRAC).
  - Quadrant encoding localparams.
  - Automatic function computing ROM entry i, used in the ROM initial block.
- One sub-module: sincos_quarter_rom. Two registered read ports, parametrised by LUT_AW, WIDTH and FRAC; provides S1.

Test Plan (defaults, macro undefined):
- Reset, then mode 0, ch0, phase 0 → 3 cycles later: out_sin=0, out_cos=16384, out_ch=0.
- Mode 0 phases 1024, 2048 and 3072 back-to-back on ch1 → three consecutive results: (16384,0), (0,-16384), (-16384,0).
- ch2: mode 0 phase 0, then four mode 1 increments of 1024 → out_phase 0, 1024, 2048, 3072, 0 (wrap), with sines 0, 16384, 0, -16384, 0.
- Interleave ch0 and ch3 accumulating by 256 and 512 for 8 requests → each channel's out_phase is the independent running sum; out_ch matches each request.
- Hold out_ready=0 for 5 cycles with 4 requests offered → in_ready drops, out_* are stable, and no result is lost or duplicated after release.
- Assert rst_n low mid-stream → out_valid=0 immediately. After release, a mode 1 increment of 100 yields out_phase=100.
